// File: rtl/uart_7bit_link.sv
// uart_7bit_link: 7-bit serial TX/RX link with 1 start bit, 7 data bits (LSB first) and 1 stop bit.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit and add parity_err.
module uart_7bit_link #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] data,
    output logic       tx,
    output logic       busy,
    input  logic       rx,
    output logic [6:0] data_out,
    output logic       valid,
    output logic       frame_err
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = PAR;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t          tx_state, tx_next;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [6:0]      tx_sh;
    logic            tx_par;
    logic            tx_tick;

    assign tx_tick = tx_cnt == LAST;
    assign busy    = tx_state != IDLE;
    assign tx      = tx_state == START ? 1'b0 :
                     tx_state == DATA  ? tx_sh[0] :
                     tx_state == PAR   ? tx_par : 1'b1;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    tx_next = start ? START : IDLE;
            START:   tx_next = tx_tick ? DATA : START;
            DATA:    tx_next = (tx_tick && tx_bit == 3'd6) ? AFTER_DATA : DATA;
            PAR:     tx_next = tx_tick ? STOP : PAR;
            STOP:    tx_next = tx_tick ? IDLE : STOP;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) tx_state <= IDLE;
        else      tx_state <= tx_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_cnt <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_state == IDLE && start) begin
                tx_sh  <= data;
                tx_par <= ^data;
                tx_bit <= '0;
            end else if (tx_state == DATA && tx_tick) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 1'b1;
            end
        end
    end

    // rx is asynchronous; only rx_s2 is used past this point
    logic            rx_s1, rx_s2;
    state_t          rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [6:0]      rx_sh;
    logic            rx_tick, rx_mid, rx_stop, rx_ok;

    assign rx_tick = rx_cnt == LAST;
    assign rx_mid  = rx_state == START && rx_cnt == HALF;
    assign rx_stop = rx_state == STOP && rx_tick;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    rx_next = rx_s2 ? IDLE : START;
            START:   rx_next = rx_mid ? (rx_s2 ? IDLE : DATA) : START;
            DATA:    rx_next = (rx_tick && rx_bit == 3'd6) ? AFTER_DATA : DATA;
            PAR:     rx_next = rx_tick ? STOP : PAR;
            STOP:    rx_next = rx_tick ? IDLE : STOP;
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) rx_state <= IDLE;
        else      rx_state <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_cnt    <= (rx_state == IDLE || rx_tick || rx_mid) ? '0 : rx_cnt + 1'b1;
            if (rx_state == START) rx_bit <= '0;
            if (rx_state == DATA && rx_tick) begin
                rx_sh  <= {rx_s2, rx_sh[6:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            valid     <= rx_stop && rx_s2 && rx_ok;
            frame_err <= rx_stop && !rx_s2;
            if (rx_stop && rx_s2 && rx_ok) data_out <= rx_sh;
        end
    end

`ifdef UART_PARITY_EN
    logic rx_pbit;
    assign rx_ok = (^rx_sh) == rx_pbit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_pbit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (rx_state == PAR && rx_tick) rx_pbit <= rx_s2;
            parity_err <= rx_stop && rx_s2 && !rx_ok;
        end
    end
`else
    assign rx_ok = 1'b1;
`endif
endmodule

// File: tb/tb_uart_7bit_link.sv
// tb_uart_7bit_link: randomized directed bench for uart_7bit_link with a frame-level reference model.
module tb_uart_7bit_link;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, rx_drv = 1'b1, loop = 1'b0;
    logic [6:0] data = '0;
    logic       tx, busy, valid, frame_err, rx;
    logic [6:0] data_out;
`ifdef UART_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0, errors = 0, ferr_cnt = 0, both_cnt = 0, ferr_exp = 0;
    logic [6:0] got[$];
    logic [6:0] exp_q[$];
    logic [6:0] last_good, c1, c2;

    assign rx = loop ? tx : rx_drv;

    uart_7bit_link #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx), .busy(busy),
        .rx(rx), .data_out(data_out), .valid(valid), .frame_err(frame_err)
`ifdef UART_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) got.push_back(data_out);
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Serial level of frame bit i for character ch
    function automatic logic exp_bit(input logic [6:0] ch, input int i);
        if (i == 0) return 1'b0;
        if (i <= 7) return ch[i-1];
`ifdef UART_PARITY_EN
        if (i == 8) return ^ch;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [6:0] ch);
        start = 1'b1;
        data  = ch;
        @(negedge clk);
    endtask

    // Called at the first negedge of a frame; ends at the idle gap after it
    task automatic tx_frame(input logic [6:0] ch, input bit chain, input logic [6:0] nxt);
        for (int k = 0; k < NB * CPB; k++) begin
            chk("tx_bit", tx, exp_bit(ch, k / CPB));
            chk("tx_busy", busy, 1);
            if (k == 0) start = 1'b0;
            if (k == 10) begin start = 1'b1; data = 7'($urandom); end
            if (k == 11) begin start = chain; data = nxt; end
            @(negedge clk);
        end
        chk("gap_busy", busy, 0);
        chk("gap_tx", tx, 1);
        if (loop) begin exp_q.push_back(ch); last_good = ch; end
    endtask

    task automatic wait_rx();
        int n = 0;
        while (got.size() != exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("rx_timeout", n < 400, 1);
        chk("rx_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk("rx_char", got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_rx(input logic [6:0] ch, input logic stopb);
        for (int b = 0; b < NB; b++) begin
            rx_drv = (b == NB - 1) ? stopb : exp_bit(ch, b);
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        if (stopb) begin exp_q.push_back(ch); last_good = ch; end
        else ferr_exp++;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_data_out", data_out, 0);
        rst = 1'b1;
        @(negedge clk);

        loop = 1'b1;
        launch(7'h41);
        tx_frame(7'h41, 1'b0, 7'h00);
        wait_rx();
        chk("a_data_out", data_out, 7'h41);

        launch(7'h55);
        tx_frame(7'h55, 1'b1, 7'h2A);
        @(negedge clk);
        tx_frame(7'h2A, 1'b0, 7'h00);
        wait_rx();

        for (int i = 0; i < 4; i++) begin
            c1 = 7'($urandom);
            c2 = 7'($urandom);
            launch(c1);
            tx_frame(c1, 1'b1, c2);
            @(negedge clk);
            tx_frame(c2, 1'b0, 7'h00);
            wait_rx();
            chk("b2b_data_out", data_out, last_good);
        end
        chk("loop_ferr", ferr_cnt, 0);

        loop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_rx(7'($urandom), 1'(i % 2));
            wait_rx();
            chk("rx_data_out", data_out, last_good);
            chk("rx_ferr", ferr_cnt, ferr_exp);
        end

        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_valid", got.size(), 0);
        chk("glitch_ferr", ferr_cnt, ferr_exp);
        chk("glitch_data_out", data_out, last_good);
        drive_rx(7'($urandom), 1'b1);
        wait_rx();

        loop = 1'b1;
        launch(7'($urandom));
        start = 1'b0;
        repeat ($urandom_range(2, 30)) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data_out", data_out, 0);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_valid", got.size(), 0);
        chk("post_rst_ferr", ferr_cnt, ferr_exp);
        chk("post_rst_busy", busy, 0);

        c1 = 7'($urandom);
        launch(c1);
        tx_frame(c1, 1'b0, 7'h00);
        wait_rx();
        chk("recover_data_out", data_out, c1);
        chk("valid_ferr_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
